// File: rtl/fabric_fifo_pkg.sv
// fabric_fifo_pkg: shared fabric error codes and payload width helper
package fabric_fifo_pkg;
  typedef enum logic [15:0] {
    FABRIC_OK             = 16'h0000,
    RT_FIFO_VALID_DROP    = 16'h0301,
    RT_FIFO_DATA_UNSTABLE = 16'h0302
  } fabric_code_e;
  function automatic int payload_width(int data_w, int tag_w);
    return data_w + tag_w;
  endfunction
endpackage

// File: rtl/fabric_fifo_if.sv
// fabric_fifo_if: valid/ready/data handshake bundle
interface fabric_fifo_if #(parameter int W = 32);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  modport master (output valid, output data, input ready);
  modport slave (input valid, input data, output ready);
endinterface

// File: rtl/fabric_fifo_hs_monitor.sv
// fabric_fifo_hs_monitor: valid/ready protocol checker with sticky first-error latch
module fabric_fifo_hs_monitor
  import fabric_fifo_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic         ready,
  input  logic [W-1:0] data,
  output logic         error_valid,
  output logic [15:0]  error_code
);
  logic         prev_stall;
  logic [W-1:0] prev_data;
  fabric_code_e code;
  always_comb code = !prev_stall ? FABRIC_OK : !valid ? RT_FIFO_VALID_DROP :
                     data != prev_data ? RT_FIFO_DATA_UNSTABLE : FABRIC_OK;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_stall  <= 1'b0;
      prev_data   <= '0;
      error_valid <= 1'b0;
      error_code  <= FABRIC_OK;
    end else begin
      prev_stall <= valid && !ready;
      prev_data  <= data;
      if (!error_valid && code != FABRIC_OK) begin
        error_valid <= 1'b1;
        error_code  <= code;
      end
    end
  end
endmodule

// File: rtl/fabric_fifo.sv
// fabric_fifo: elastic valid/ready buffer with protocol monitor; `FABRIC_FIFO_BYPASS_EN adds 0-cycle empty bypass
module fabric_fifo
  import fabric_fifo_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH = 0,
  localparam int PAYLOAD_WIDTH = payload_width(DATA_WIDTH, TAG_WIDTH),
  localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  fabric_fifo_if.slave         in_if,
  fabric_fifo_if.master        out_if,
  output logic [CNT_WIDTH-1:0] occupancy,
  output logic                 error_valid,
  output logic [15:0]          error_code
);
  localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  if (DEPTH < 1 || DEPTH > 256) begin : g_depth_chk
    $fatal(1, "CPL_FIFO_DEPTH_RANGE");
  end
  logic [PAYLOAD_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic                     empty, byp, push, pop;
  always_comb begin
    empty = occupancy == '0;
`ifdef FABRIC_FIFO_BYPASS_EN
    byp = empty && in_if.valid && out_if.ready;
`else
    byp = 1'b0;
`endif
    in_if.ready  = occupancy < CNT_WIDTH'(DEPTH);
    push         = in_if.valid && in_if.ready && !byp;
    pop          = !empty && out_if.ready;
    out_if.valid = !empty || byp;
    out_if.data  = byp ? in_if.data : empty ? '0 : mem[rd_ptr];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == PTR_W'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == PTR_W'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      occupancy <= occupancy + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= in_if.data;
  fabric_fifo_hs_monitor #(.W(PAYLOAD_WIDTH)) u_mon (
    .clk(clk),
    .rst(rst),
    .valid(in_if.valid),
    .ready(in_if.ready),
    .data(in_if.data),
    .error_valid(error_valid),
    .error_code(error_code)
  );
endmodule

// File: tb/tb_fabric_fifo.sv
// tb_fabric_fifo: randomized and directed checks of fabric_fifo against a queue model
module tb_fabric_fifo;
  import fabric_fifo_pkg::*;
  localparam int DEPTH = 3;
  localparam int DW = 16;
  localparam int TW = 4;
  localparam int PW = DW + TW;
  localparam int CW = $clog2(DEPTH + 1);
`ifdef FABRIC_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CW-1:0] occupancy;
  logic error_valid;
  logic [15:0] error_code;
  int checks = 0;
  int fails = 0;
  logic [PW-1:0] q[$];
  fabric_fifo_if #(.W(PW)) in_if ();
  fabric_fifo_if #(.W(PW)) out_if ();
  fabric_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk(clk),
    .rst(rst),
    .in_if(in_if.slave),
    .out_if(out_if.master),
    .occupancy(occupancy),
    .error_valid(error_valid),
    .error_code(error_code)
  );
  always #5 clk = ~clk;
  function automatic bit m_byp();
    return BYP && q.size() == 0 && in_if.valid && out_if.ready;
  endfunction
  function automatic bit m_ready();
    return q.size() < DEPTH;
  endfunction
  function automatic bit m_valid();
    return q.size() != 0 || m_byp();
  endfunction
  function automatic logic [PW-1:0] m_data();
    return m_byp() ? in_if.data : q.size() != 0 ? q[0] : '0;
  endfunction
  task automatic drive(input logic v, input logic [PW-1:0] d, input logic r);
    in_if.valid = v;
    in_if.data = d;
    out_if.ready = r;
    #1;
  endtask
  task automatic tick();
    bit b, pu, po;
    logic [PW-1:0] d;
    b = m_byp();
    pu = in_if.valid && m_ready() && !b;
    po = q.size() != 0 && out_if.ready;
    d = in_if.data;
    @(posedge clk);
    if (po) void'(q.pop_front());
    if (pu) q.push_back(d);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    in_if.valid = 1'b0;
    in_if.data = '0;
    out_if.ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
  endtask
  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (in_if.ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_if.ready); end
    checks++; if (out_if.valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_if.valid); end
    checks++; if (out_if.data !== '0) begin fails++; $display("FAIL reset_out_data: got %h want 0", out_if.data); end
    checks++; if (occupancy !== '0) begin fails++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    checks++; if (error_valid !== 1'b0 || error_code !== FABRIC_OK) begin fails++; $display("FAIL reset_err: got %b/%h want 0/%h", error_valid, error_code, FABRIC_OK); end
  endtask
  task automatic test_fill_drain();
    logic [PW-1:0] tok[4];
    for (int i = 0; i < 4; i++) tok[i] = {4'(i + 1), 16'(32'hA + i)};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, tok[i], 1'b0);
      checks++; if (in_if.ready !== (i < DEPTH)) begin fails++; $display("FAIL fill_ready[%0d]: got %b want %b", i, in_if.ready, i < DEPTH); end
      checks++; if (occupancy !== CW'(i < DEPTH ? i : DEPTH)) begin fails++; $display("FAIL fill_occ[%0d]: got %0d", i, occupancy); end
      tick();
    end
    for (int j = 0; j < 4; j++) begin
      drive(j < 2, j < 2 ? tok[3] : '0, 1'b1);
      checks++; if (out_if.valid !== 1'b1 || out_if.data !== tok[j]) begin fails++; $display("FAIL drain_data[%0d]: got %b/%h want 1/%h", j, out_if.valid, out_if.data, tok[j]); end
      checks++; if (in_if.ready !== (j != 0)) begin fails++; $display("FAIL drain_ready[%0d]: got %b want %b", j, in_if.ready, j != 0); end
      tick();
    end
    checks++; if (occupancy !== '0) begin fails++; $display("FAIL drain_empty: got %0d want 0", occupancy); end
  endtask
  task automatic test_throughput();
    logic [PW-1:0] dat[10];
    logic ev;
    logic [PW-1:0] ed;
    for (int i = 0; i < 10; i++) dat[i] = PW'($urandom);
    for (int i = 0; i <= 10; i++) begin
      drive(i < 10, i < 10 ? dat[i] : '0, 1'b1);
      ev = BYP ? i < 10 : i > 0;
      ed = BYP ? (i < 10 ? dat[i] : '0) : (i > 0 ? dat[i-1] : '0);
      checks++; if (out_if.valid !== ev || out_if.data !== ed) begin fails++; $display("FAIL thru_out[%0d]: got %b/%h want %b/%h", i, out_if.valid, out_if.data, ev, ed); end
      checks++; if (occupancy !== CW'(!BYP && i > 0)) begin fails++; $display("FAIL thru_occ[%0d]: got %0d", i, occupancy); end
      checks++; if (in_if.ready !== 1'b1) begin fails++; $display("FAIL thru_ready[%0d]: got %b want 1", i, in_if.ready); end
      tick();
    end
  endtask
  task automatic test_full_pop();
    logic [PW-1:0] t[3];
    logic [PW-1:0] x;
    x = {4'h3, 16'hBEEF};
    for (int i = 0; i < 3; i++) begin
      t[i] = {4'hF, 16'(32'h100 + i)};
      drive(1'b1, t[i], 1'b0);
      tick();
    end
    drive(1'b1, x, 1'b1);
    checks++; if (in_if.ready !== 1'b0) begin fails++; $display("FAIL fullpop_ready: got %b want 0", in_if.ready); end
    checks++; if (out_if.data !== t[0]) begin fails++; $display("FAIL fullpop_head: got %h want %h", out_if.data, t[0]); end
    tick();
    checks++; if (occupancy !== CW'(DEPTH - 1)) begin fails++; $display("FAIL fullpop_occ: got %0d want %0d", occupancy, DEPTH - 1); end
    drive(1'b1, x, 1'b1);
    checks++; if (out_if.data !== t[1] || in_if.ready !== 1'b1) begin fails++; $display("FAIL fullpop_second: got %h/%b want %h/1", out_if.data, in_if.ready, t[1]); end
    tick();
    drive(1'b0, '0, 1'b1);
    checks++; if (out_if.data !== t[2]) begin fails++; $display("FAIL fullpop_third: got %h want %h", out_if.data, t[2]); end
    tick();
    checks++; if (out_if.data !== x || out_if.valid !== 1'b1) begin fails++; $display("FAIL fullpop_held: got %b/%h want 1/%h", out_if.valid, out_if.data, x); end
    tick();
    checks++; if (out_if.valid !== 1'b0 || occupancy !== '0) begin fails++; $display("FAIL fullpop_empty: got %b/%0d want 0/0", out_if.valid, occupancy); end
  endtask
  task automatic test_bypass_path();
    logic [PW-1:0] z;
    z = {4'hC, 16'h1234};
    drive(1'b1, z, 1'b1);
    checks++; if (out_if.valid !== BYP || out_if.data !== (BYP ? z : '0)) begin fails++; $display("FAIL bypass_same: got %b/%h want %b/%h", out_if.valid, out_if.data, BYP, BYP ? z : '0); end
    tick();
    checks++; if (occupancy !== CW'(!BYP)) begin fails++; $display("FAIL bypass_occ: got %0d want %0d", occupancy, !BYP); end
    drive(1'b0, '0, 1'b1);
    checks++; if (out_if.valid !== !BYP || out_if.data !== (BYP ? '0 : z)) begin fails++; $display("FAIL bypass_next: got %b/%h want %b/%h", out_if.valid, out_if.data, !BYP, BYP ? '0 : z); end
    tick();
  endtask
  task automatic test_random();
    bit stall;
    logic v;
    logic [PW-1:0] d;
    stall = 1'b0;
    v = 1'b0;
    d = '0;
    for (int i = 0; i < 300; i++) begin
      if (!stall) begin
        v = $urandom_range(0, 3) != 0;
        d = PW'($urandom);
      end
      drive(v, d, 1'($urandom_range(0, 1)));
      checks++; if (in_if.ready !== m_ready()) begin fails++; $display("FAIL rand_ready[%0d]: got %b want %b", i, in_if.ready, m_ready()); end
      checks++; if (out_if.valid !== m_valid() || out_if.data !== m_data()) begin fails++; $display("FAIL rand_out[%0d]: got %b/%h want %b/%h", i, out_if.valid, out_if.data, m_valid(), m_data()); end
      checks++; if (occupancy !== CW'(q.size())) begin fails++; $display("FAIL rand_occ[%0d]: got %0d want %0d", i, occupancy, q.size()); end
      checks++; if (error_valid !== 1'b0) begin fails++; $display("FAIL rand_err[%0d]: got %b want 0", i, error_valid); end
      stall = v && !m_ready();
      tick();
    end
  endtask
  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, PW'(32'h77 + i), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    checks++; if (occupancy !== CW'(2)) begin fails++; $display("FAIL arst_pre_occ: got %0d want 2", occupancy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_if.valid !== 1'b0 || out_if.data !== '0) begin fails++; $display("FAIL arst_out: got %b/%h want 0/0", out_if.valid, out_if.data); end
    checks++; if (occupancy !== '0 || in_if.ready !== 1'b1) begin fails++; $display("FAIL arst_occ: got %0d/%b want 0/1", occupancy, in_if.ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    drive(1'b0, '0, 1'b1);
    tick();
    checks++; if (out_if.valid !== 1'b0 || error_valid !== 1'b0) begin fails++; $display("FAIL arst_after: got %b/%b want 0/0", out_if.valid, error_valid); end
  endtask
  task automatic test_valid_drop();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, PW'(i), 1'b0);
      tick();
    end
    drive(1'b1, PW'(5), 1'b0);
    tick();
    checks++; if (error_valid !== 1'b0) begin fails++; $display("FAIL drop_pre: got %b want 0", error_valid); end
    drive(1'b0, '0, 1'b0);
    tick();
    checks++; if (error_valid !== 1'b1 || error_code !== RT_FIFO_VALID_DROP) begin fails++; $display("FAIL drop_code: got %b/%h want 1/%h", error_valid, error_code, RT_FIFO_VALID_DROP); end
    drive(1'b1, PW'(5), 1'b0);
    tick();
    drive(1'b1, PW'(6), 1'b0);
    tick();
    checks++; if (error_code !== RT_FIFO_VALID_DROP) begin fails++; $display("FAIL drop_sticky: got %h want %h", error_code, RT_FIFO_VALID_DROP); end
  endtask
  task automatic test_data_unstable();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, PW'(i + 8), 1'b0);
      tick();
    end
    drive(1'b1, PW'(5), 1'b0);
    tick();
    drive(1'b1, PW'(6), 1'b0);
    tick();
    checks++; if (error_valid !== 1'b1 || error_code !== RT_FIFO_DATA_UNSTABLE) begin fails++; $display("FAIL unstable_code: got %b/%h want 1/%h", error_valid, error_code, RT_FIFO_DATA_UNSTABLE); end
    drive(1'b0, '0, 1'b1);
    checks++; if (out_if.data !== PW'(8)) begin fails++; $display("FAIL unstable_head: got %h want 8", out_if.data); end
    tick();
    checks++; if (occupancy !== CW'(DEPTH - 1) || error_code !== RT_FIFO_DATA_UNSTABLE) begin fails++; $display("FAIL unstable_keep: got %0d/%h want %0d/%h", occupancy, error_code, DEPTH - 1, RT_FIFO_DATA_UNSTABLE); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    in_if.valid = 1'b0;
    in_if.data = '0;
    out_if.ready = 1'b0;
    test_reset();
    test_fill_drain();
    test_throughput();
    test_full_pop();
    test_bypass_path();
    test_random();
    test_async_reset();
    test_valid_drop();
    test_data_unstable();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
